// File: rtl/cpu_ins_encoder.sv
// Instruction encoder/streamer: turns one-hot MIPS instruction selects plus fields into
// 32-bit instruction words with sequential word addresses for instruction-memory loading.
module cpu_ins_encoder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_sel,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_word_q, out_word_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                sel_legal;
    logic [4:0]          sel_id;
    logic [31:0]         enc_word;
    logic [5:0]          funct, opcode;
    logic                is_r, is_j;
    logic [4:0]          r_rt, r_rd, r_sh;
    logic                in_fire, out_fire;

    // Legal select: exactly one bit within [30:0], reserved bit 31 clear.
    always_comb begin
        sel_legal = !in_sel[31] && (in_sel[30:0] != '0) &&
                    ((in_sel[30:0] & (in_sel[30:0] - 31'd1)) == '0);
        sel_id = '0;
        for (int i = 0; i < 31; i++) begin
            if (in_sel[i]) sel_id = 5'(i);
        end
    end

    always_comb begin
        funct  = '0;
        opcode = '0;
        is_r   = 1'b0;
        is_j   = 1'b0;
        case (sel_id)
            5'd0:  begin is_r = 1'b1; funct = 6'b100000; end
            5'd1:  begin is_r = 1'b1; funct = 6'b100001; end
            5'd2:  begin is_r = 1'b1; funct = 6'b100010; end
            5'd3:  begin is_r = 1'b1; funct = 6'b100011; end
            5'd4:  begin is_r = 1'b1; funct = 6'b100100; end
            5'd5:  begin is_r = 1'b1; funct = 6'b100101; end
            5'd6:  begin is_r = 1'b1; funct = 6'b100110; end
            5'd7:  begin is_r = 1'b1; funct = 6'b100111; end
            5'd8:  begin is_r = 1'b1; funct = 6'b101010; end
            5'd9:  begin is_r = 1'b1; funct = 6'b101011; end
            5'd10: begin is_r = 1'b1; funct = 6'b000000; end
            5'd11: begin is_r = 1'b1; funct = 6'b000010; end
            5'd12: begin is_r = 1'b1; funct = 6'b000011; end
            5'd13: begin is_r = 1'b1; funct = 6'b000100; end
            5'd14: begin is_r = 1'b1; funct = 6'b000110; end
            5'd15: begin is_r = 1'b1; funct = 6'b000111; end
            5'd16: begin is_r = 1'b1; funct = 6'b001000; end
            5'd17: opcode = 6'b001000;
            5'd18: opcode = 6'b001001;
            5'd19: opcode = 6'b001100;
            5'd20: opcode = 6'b001101;
            5'd21: opcode = 6'b001110;
            5'd22: opcode = 6'b100011;
            5'd23: opcode = 6'b101011;
            5'd24: opcode = 6'b000100;
            5'd25: opcode = 6'b000101;
            5'd26: opcode = 6'b001010;
            5'd27: opcode = 6'b001011;
            5'd28: opcode = 6'b001111;
            5'd29: begin is_j = 1'b1; opcode = 6'b000010; end
            5'd30: begin is_j = 1'b1; opcode = 6'b000011; end
            default: opcode = '0;
        endcase
    end

    // Only the immediate shifts carry shamt; jr carries rs alone.
    always_comb begin
        r_rt = in_rt;
        r_rd = in_rd;
        r_sh = (sel_id == 5'd10 || sel_id == 5'd11 || sel_id == 5'd12) ? in_shamt : 5'd0;
        if (sel_id == 5'd16) begin
            r_rt = '0;
            r_rd = '0;
        end
        if (is_r) begin
            enc_word = {6'b000000, in_rs, r_rt, r_rd, r_sh, funct};
        end else if (is_j) begin
            enc_word = {opcode, in_target};
        end else begin
            enc_word = {opcode, (sel_id == 5'd28) ? 5'd0 : in_rs, in_rt, in_imm};
        end
    end

    assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = base_addr;
                    rem_d     = len;
                    err_cnt_d = '0;
                    // An empty burst completes immediately; DRAIN then just returns to IDLE.
                    done_d    = (len == '0);
                    state_d   = (len == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                if (in_fire) begin
                    if (sel_legal) begin
                        out_valid_d = 1'b1;
                        out_word_d  = enc_word;
                        rem_d       = rem_q - 1'b1;
                        if (rem_q == (ADDR_W+1)'(1)) state_d = StDrain;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            StDrain: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StIdle;
                    done_d  = out_valid_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_addr  = addr_q;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule
